// File: rtl/f1_start_seq.sv
// f1_start_seq: F1 start-light sequencer with random hold and reaction timing.
//   clk, rst     : clock, synchronous active-high reset
//   tick         : one-cycle step strobe from the prescaler
//   trigger      : start request, rising edge detected internally
//   stop         : driver reaction input, sampled every clk
//   data_out     : light outputs, bit 0 is the first light
//   busy         : high whenever the sequencer is not idle
//   lights_out   : one-cycle pulse on the all-lights-off event
//   react_valid  : one-cycle pulse when react_time is updated
//   react_time   : last measured reaction in clk cycles (saturating)
//   false_start  : one-cycle pulse when stop arrives before lights-out
module f1_start_seq #(
    parameter int          N_LIGHTS  = 8,
    parameter int          DELAY_W   = 4,
    parameter int          RT_W      = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                trigger,
    input  logic                stop,
    output logic [N_LIGHTS-1:0] data_out,
    output logic                busy,
    output logic                lights_out,
    output logic                react_valid,
    output logic [RT_W-1:0]     react_time,
    output logic                false_start
);
    typedef enum logic [1:0] {IDLE, FILL, HOLD, TIMING} state_t;

    state_t              state_q, state_d;
    logic [N_LIGHTS-1:0] data_q, data_d;
    logic [DELAY_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [RT_W-1:0]     rcnt_q, rcnt_d;
    logic [RT_W-1:0]     rt_q, rt_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic                trig_q;
    logic                lo_q, lo_d;
    logic                rv_q, rv_d;
    logic                fs_q, fs_d;
    logic                rise;

    always_comb begin
        rise       = trigger & ~trig_q;
        // Fibonacci LFSR, x^16+x^14+x^13+x^11+1 in right-shift form
        lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        state_d    = state_q;
        data_d     = data_q;
        hold_cnt_d = hold_cnt_q;
        rcnt_d     = rcnt_q;
        rt_d       = rt_q;
        lo_d       = 1'b0;
        rv_d       = 1'b0;
        fs_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = FILL;
                    data_d  = '0;
                end
            end
            FILL, HOLD: begin
                // stop outranks tick: any stop before lights-out is a false start
                if (stop) begin
                    data_d  = '0;
                    fs_d    = 1'b1;
                    state_d = IDLE;
                end else if (tick) begin
                    if (state_q == FILL) begin
                        if (&data_q) begin
                            state_d    = HOLD;
                            hold_cnt_d = lfsr_q[DELAY_W-1:0];
                        end else begin
                            data_d = {data_q[N_LIGHTS-2:0], 1'b1};
                        end
                    end else if (hold_cnt_q == '0) begin
                        data_d  = '0;
                        lo_d    = 1'b1;
                        rcnt_d  = '0;
                        state_d = TIMING;
                    end else begin
                        hold_cnt_d = hold_cnt_q - DELAY_W'(1);
                    end
                end
            end
            TIMING: begin
                if (stop) begin
                    rt_d    = rcnt_q;
                    rv_d    = 1'b1;
                    state_d = IDLE;
                end else if (~&rcnt_q) begin
                    rcnt_d = rcnt_q + RT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            hold_cnt_q <= '0;
            rcnt_q     <= '0;
            rt_q       <= '0;
            lfsr_q     <= LFSR_SEED;
            trig_q     <= 1'b0;
            lo_q       <= 1'b0;
            rv_q       <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            hold_cnt_q <= hold_cnt_d;
            rcnt_q     <= rcnt_d;
            rt_q       <= rt_d;
            lfsr_q     <= lfsr_d;
            trig_q     <= trigger;
            lo_q       <= lo_d;
            rv_q       <= rv_d;
            fs_q       <= fs_d;
        end
    end

    assign data_out    = data_q;
    assign busy        = (state_q != IDLE);
    assign lights_out  = lo_q;
    assign react_valid = rv_q;
    assign react_time  = rt_q;
    assign false_start = fs_q;
endmodule

// File: tb/tb_f1_start_seq.sv
// tb_f1_start_seq: randomized and directed check of f1_start_seq against a behavioural model.
module tb_f1_start_seq;
    logic clk = 1'b0;
    logic rst = 1'b1, tick = 1'b0, trigger = 1'b0, stop = 1'b0;
    logic [7:0]  data_a, data_b;
    logic        busy_a, busy_b, lo_a, lo_b, rv_a, rv_b, fs_a, fs_b;
    logic [15:0] rt_a;
    logic [3:0]  rt_b;
    int total = 0, bad = 0, cyc = 0;
    bit started = 0, rand_tick = 0;

    always #5 clk = ~clk;

    f1_start_seq dut_a (
        .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .stop(stop),
        .data_out(data_a), .busy(busy_a), .lights_out(lo_a),
        .react_valid(rv_a), .react_time(rt_a), .false_start(fs_a)
    );

    f1_start_seq #(.RT_W(4)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .stop(stop),
        .data_out(data_b), .busy(busy_b), .lights_out(lo_b),
        .react_valid(rv_b), .react_time(rt_b), .false_start(fs_b)
    );

    // Model: mode 0 idle, 1 filling, 2 holding, 3 timing; lights lit as a count,
    // reaction counted unbounded and clamped only when compared.
    int          m_mode, m_lit, m_hold, m_rcnt, e_rt;
    logic [15:0] m_lfsr;
    logic        m_trig;
    logic [7:0]  e_data;
    logic        e_busy, e_lo, e_rv, e_fs;

    always @(posedge clk) begin
        logic [15:0] lf;
        logic        rise;
        started = 1;
        e_lo = 0; e_rv = 0; e_fs = 0;
        if (rst) begin
            m_mode = 0; m_lit = 0; m_hold = 0; m_rcnt = 0; e_rt = 0;
            m_lfsr = 16'hACE1; m_trig = 0;
        end else begin
            lf     = m_lfsr;
            m_lfsr = {^(m_lfsr & 16'h002D), m_lfsr[15:1]};
            rise   = trigger && !m_trig;
            m_trig = trigger;
            if (m_mode == 0) begin
                if (rise) begin m_mode = 1; m_lit = 0; end
            end else if (m_mode == 3) begin
                if (stop) begin e_rt = m_rcnt; e_rv = 1; m_mode = 0; end
                else m_rcnt++;
            end else if (stop) begin
                m_lit = 0; e_fs = 1; m_mode = 0;
            end else if (tick) begin
                if (m_mode == 1) begin
                    if (m_lit < 8) m_lit++;
                    else begin m_mode = 2; m_hold = int'(lf & 16'h000F); end
                end else if (m_hold == 0) begin
                    m_lit = 0; e_lo = 1; m_rcnt = 0; m_mode = 3;
                end else m_hold--;
            end
        end
        e_data = 8'((1 << m_lit) - 1);
        e_busy = (m_mode != 0);
    end

    always @(negedge clk) begin
        if (started) begin
            total++;
            if ({data_a, busy_a, lo_a, rv_a, fs_a} !== {e_data, e_busy, e_lo, e_rv, e_fs} ||
                {data_b, busy_b, lo_b, rv_b, fs_b} !== {e_data, e_busy, e_lo, e_rv, e_fs} ||
                rt_a !== 16'(e_rt > 65535 ? 65535 : e_rt) ||
                rt_b !== 4'(e_rt > 15 ? 15 : e_rt)) begin
                bad++;
                $display("FAIL model cyc=%0d got data=%h/%h busy=%b/%b lo=%b/%b rv=%b/%b fs=%b/%b rt=%0d/%0d exp data=%h busy=%b lo=%b rv=%b fs=%b rt=%0d",
                         cyc, data_a, data_b, busy_a, busy_b, lo_a, lo_b, rv_a, rv_b, fs_a, fs_b,
                         rt_a, rt_b, e_data, e_busy, e_lo, e_rv, e_fs, e_rt);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        tick = rand_tick ? ($urandom_range(0, 2) == 0) : (cyc % 4 == 0);
    endtask

    task automatic wait_lo();
        for (int i = 0; i < 300; i++) begin
            step();
            if (lo_a) return;
        end
        chk("lights_out_timeout", 0, 1);
    endtask

    task automatic start();
        trigger = 1;
        step();
        trigger = 0;
    endtask

    initial begin
        logic [7:0] prev;
        logic       t, pb;
        int         rises;
        // reset
        step(); step();
        chk("rst_data", data_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_rt", rt_a, 0);
        chk("rst_pulses", {lo_a, rv_a, fs_a}, 0);
        rst = 0;
        // full sequence
        start();
        chk("fill_busy", busy_a, 1);
        chk("fill_data0", data_a, 0);
        for (int i = 0; i < 8; i++) begin
            prev = data_a;
            for (int j = 0; j < 10 && data_a == prev; j++) step();
            chk("fill_step", data_a, (32'd1 << (i + 1)) - 1);
        end
        wait_lo();
        chk("lo_data", data_a, 0);
        repeat (37) step();
        stop = 1;
        step();
        stop = 0;
        chk("react_valid", rv_a, 1);
        chk("react_37", rt_a, 37);
        chk("react_sat_37", rt_b, 15);
        chk("react_busy", busy_a, 0);
        step();
        chk("react_valid_1cyc", rv_a, 0);
        // false start
        start();
        for (int j = 0; j < 40 && data_a != 8'h07; j++) step();
        stop = 1;
        step();
        stop = 0;
        chk("fs_pulse", fs_a, 1);
        chk("fs_data", data_a, 0);
        chk("fs_busy", busy_a, 0);
        chk("fs_rv", rv_a, 0);
        chk("fs_rt_kept", rt_a, 37);
        step();
        // held trigger, then repeated edges while busy
        trigger = 1;
        rises = 0;
        pb = busy_a;
        repeat (100) begin
            step();
            if (busy_a && !pb) rises++;
            pb = busy_a;
        end
        chk("held_trigger_one_seq", rises, 1);
        repeat (150) begin
            trigger = (cyc % 3 == 0);
            step();
            if (busy_a && !pb) rises++;
            pb = busy_a;
        end
        trigger = 0;
        chk("retrigger_no_restart", rises, 1);
        chk("retrigger_busy", busy_a, 1);
        stop = 1;
        step();
        stop = 0;
        chk("retrigger_rv", rv_a, 1);
        // saturation
        start();
        wait_lo();
        repeat (20) step();
        stop = 1;
        step();
        stop = 0;
        chk("sat_rt16", rt_a, 20);
        chk("sat_rt4", rt_b, 15);
        // reset in HOLD
        start();
        for (int j = 0; j < 60 && data_a != 8'hFF; j++) step();
        for (int j = 0; j < 10; j++) begin
            t = tick;
            step();
            if (t) break;
        end
        chk("hold_data", data_a, 8'hFF);
        rst = 1;
        step();
        rst = 0;
        chk("rst_hold_data", data_a, 0);
        chk("rst_hold_busy", busy_a, 0);
        chk("rst_hold_rt", rt_a, 0);
        chk("rst_hold_pulses", {lo_a, rv_a, fs_a, lo_b, rv_b, fs_b}, 0);
        start();
        wait_lo();
        repeat (5) step();
        stop = 1;
        step();
        stop = 0;
        chk("after_rst_rt", rt_a, 5);
        // random traffic
        rand_tick = 1;
        repeat (4000) begin
            trigger = ($urandom_range(0, 5) == 0);
            stop    = ($urandom_range(0, 39) == 0);
            rst     = ($urandom_range(0, 699) == 0);
            step();
        end
        rst = 0; trigger = 0; stop = 0;
        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
